// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link: slot codes, alignment states
// and the slot-order rule used by both the multiplexer and the demultiplexer.
package tdm_pkg;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'b00;
    localparam slot_t SLOT_B = 2'b01;
    localparam slot_t SLOT_C = 2'b10;
    localparam slot_t SLOT_D = 2'b11;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Slots are sent a, b, c, d and then wrap back to a.
    function automatic slot_t next_slot(input slot_t s);
        return s + 2'b01;
    endfunction

    // Only the slot-a sample carries the sync marker.
    function automatic logic sync_expected(input slot_t s);
        return (s == SLOT_A);
    endfunction

    function automatic logic is_last_slot(input slot_t s);
        return (s == SLOT_D);
    endfunction

endpackage

// File: rtl/tdm_demux4.sv
// Receive side of the 4-to-1 TDM link: aligns to the slot-a sync marker and
// presents each completed frame on four registered channel outputs.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic [WIDTH-1:0] dout_c,
    output logic [WIDTH-1:0] dout_d,
    output logic             frame_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err
);

    state_t           state_q, state_d;
    slot_t            slot_q, slot_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_c_q, sh_c_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= SLOT_A;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_c_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            out_c_q <= '0;
            out_d_q <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_c_q  <= sh_c_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            out_c_q <= out_c_d;
            out_d_q <= out_d_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_c_d  = sh_c_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        out_c_d = out_c_q;
        out_d_d = out_d_q;
        frame_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (din_valid && sync) begin
                    sh_a_d  = din;
                    slot_d  = SLOT_B;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    if (sync && !sync_expected(slot_q)) begin
                        // Early marker: restart the frame on this sample.
                        err_d  = 1'b1;
                        sh_a_d = din;
                        slot_d = SLOT_B;
                    end else if (!sync && sync_expected(slot_q)) begin
                        // Marker missing where it must be: alignment is lost.
                        err_d   = 1'b1;
                        slot_d  = SLOT_A;
                        state_d = HUNT;
                    end else begin
                        unique case (slot_q)
                            SLOT_A: sh_a_d = din;
                            SLOT_B: sh_b_d = din;
                            SLOT_C: sh_c_d = din;
                            default: ;
                        endcase
                        if (is_last_slot(slot_q)) begin
                            out_a_d = sh_a_q;
                            out_b_d = sh_b_q;
                            out_c_d = sh_c_q;
                            out_d_d = din;
                            frame_d = 1'b1;
                        end
                        slot_d = next_slot(slot_q);
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = SLOT_A;
            end
        endcase
    end

    assign dout_a      = out_a_q;
    assign dout_b      = out_b_q;
    assign dout_c      = out_c_q;
    assign dout_d      = out_d_q;
    assign frame_valid = frame_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == LOCKED);
    assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed samples push expected frames and
// sync errors; a negedge monitor pops and compares whenever the DUT pulses.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       sync;
    logic [7:0] dout_a, dout_b, dout_c, dout_d;
    logic       frame_valid, locked, sync_err;
    logic [1:0] slot;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] a, b, c, d;
        int         cyc;
    } frame_t;

    frame_t fq[$];
    int     eq[$];

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c), .dout_d(dout_d),
        .frame_valid(frame_valid), .locked(locked), .slot(slot), .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every frame_valid / sync_err pulse against the queues.
    always @(negedge clk) begin
        if (frame_valid) begin
            if (fq.size() == 0) begin
                check("unexpected_frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                frame_t f;
                f = fq.pop_front();
                check("frame_cycle", 32'(cyc), 32'(f.cyc));
                check("dout_a", 32'(dout_a), 32'(f.a));
                check("dout_b", 32'(dout_b), 32'(f.b));
                check("dout_c", 32'(dout_c), 32'(f.c));
                check("dout_d", 32'(dout_d), 32'(f.d));
            end
            if (sync_err) check("err_with_frame", 32'(sync_err), 32'd0);
        end
        if (sync_err) begin
            if (eq.size() == 0) check("unexpected_sync_err", 32'(sync_err), 32'd0);
            else check("sync_err_cycle", 32'(cyc), 32'(eq.pop_front()));
        end
    end

    // Drive one cycle; sample is accepted at the next rising edge.
    task automatic send(input logic [7:0] d, input logic s, input logic v = 1'b1);
        din = d;
        sync = s;
        din_valid = v;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input logic [7:0] a, b, c, d);
        frame_t f;
        f.a = a; f.b = b; f.c = c; f.d = d;
        f.cyc = cyc;
        fq.push_back(f);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout_a"}, 32'(dout_a), 32'd0);
        check({tag, "_dout_d"}, 32'(dout_d), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_slot"}, 32'(slot), 32'd0);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        sync = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero("reset");
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic frame
        do_reset();
        send(8'h11, 1'b1);
        check("lock_on_sync", 32'(locked), 32'd1);
        check("slot_after_sync", 32'(slot), 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
        check("locked_after_frame", 32'(locked), 32'd1);
        check("slot_after_frame", 32'(slot), 32'd0);
        idle(2);

        // No sync marker: nothing is accepted
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h55, 1'b0);
        idle(2);
        check_zero("nosync");

        // Gaps inside a frame
        do_reset();
        send(8'h11, 1'b1); idle(2);
        send(8'h22, 1'b0); idle(2);
        send(8'h33, 1'b0); idle(2);
        check("gap_slot", 32'(slot), 32'd3);
        send(8'h44, 1'b0);
        expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
        idle(2);

        // Early sync realigns and drops the partial frame
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b0);
        send(8'hB1, 1'b1);
        eq.push_back(cyc);
        check("realign_slot", 32'(slot), 32'd1);
        check("realign_locked", 32'(locked), 32'd1);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        check("hold_dout_a", 32'(dout_a), 32'h11);
        check("hold_dout_d", 32'(dout_d), 32'h44);
        send(8'hB4, 1'b0);
        expect_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        idle(1);

        // Missing sync on slot a drops lock; next sync relocks
        send(8'h66, 1'b0);
        eq.push_back(cyc);
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_slot", 32'(slot), 32'd0);
        idle(1);
        check("unlock_hold_dout_b", 32'(dout_b), 32'hB2);
        send(8'h77, 1'b1);
        send(8'h88, 1'b0);
        send(8'h99, 1'b0);
        send(8'hAA, 1'b0);
        expect_frame(8'h77, 8'h88, 8'h99, 8'hAA);
        idle(2);

        // Reset mid-frame
        send(8'hC1, 1'b1);
        send(8'hC2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero("midreset");
        send(8'hD1, 1'b1);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        expect_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4);

        // Back-to-back frames at full rate
        send(8'hE1, 1'b1); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
        expect_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4);
        send(8'hF1, 1'b1); send(8'hF2, 1'b0); send(8'hF3, 1'b0); send(8'hF4, 1'b0);
        expect_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4);
        idle(4);

        check("frames_outstanding", 32'(fq.size()), 32'd0);
        check("errs_outstanding", 32'(eq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
